// File: rtl/clock_pkg.sv
// Shared encodings and default timing constants for the alarm/snooze controller.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RINGING  = 2'b01,
        ST_SNOOZING = 2'b10
    } state_t;

    localparam int RING_SECS   = 60;
    localparam int SNOOZE_SECS = 300;
    localparam int MAX_SNOOZE  = 3;
    localparam int BEEP_DIV    = 15000000;

endpackage

// File: rtl/tc_counter.sv
// Modulo-MOD up-counter with synchronous clear and a terminal-count flag.
module tc_counter #(
    parameter int MOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);
    localparam int W = (MOD > 1) ? $clog2(MOD) : 1;
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tc ? '0 : cnt + 1'b1;
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/alarm_snooze_ctrl.sv
// Alarm ring/snooze/dismiss sequencer with bounded snoozes, auto-timeout and beep gating.
module alarm_snooze_ctrl
    import clock_pkg::*;
#(
    parameter int RING_SECS   = clock_pkg::RING_SECS,
    parameter int SNOOZE_SECS = clock_pkg::SNOOZE_SECS,
    parameter int MAX_SNOOZE  = clock_pkg::MAX_SNOOZE,
    parameter int BEEP_DIV    = clock_pkg::BEEP_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       match,
    input  logic       armed,
    input  logic       adjust,
    input  logic       snooze_btn,
    input  logic       dismiss_btn,
    output logic       alarm_on,
    output logic       buzzer_en,
    output logic       snooze_led,
    output logic [1:0] state,
    output logic [1:0] snooze_count
);
    localparam logic [1:0] MAX_SNZ = 2'(MAX_SNOOZE);

    state_t     cur_st, nxt_st;
    logic [1:0] cnt_nx;
    logic       match_d, trig, phase;
    logic       ring_tc, snz_tc, beep_tc;
    logic       in_ring, in_snz;

    assign in_ring = (cur_st == ST_RINGING);
    assign in_snz  = (cur_st == ST_SNOOZING);
    assign trig    = match & ~match_d & armed & ~adjust;

    // Counters sit cleared outside their state, so every entry starts from zero.
    tc_counter #(.MOD(RING_SECS)) u_ring (
        .clk(clk), .rst(rst), .en(in_ring & sec_tick), .clr(~in_ring), .tc(ring_tc)
    );
    tc_counter #(.MOD(SNOOZE_SECS)) u_snz (
        .clk(clk), .rst(rst), .en(in_snz & sec_tick), .clr(~in_snz), .tc(snz_tc)
    );
    tc_counter #(.MOD(BEEP_DIV)) u_beep (
        .clk(clk), .rst(rst), .en(in_ring), .clr(~in_ring), .tc(beep_tc)
    );

    always_comb begin
        nxt_st = cur_st;
        cnt_nx = snooze_count;
        case (cur_st)
            ST_IDLE: begin
                if (trig) begin
                    nxt_st = ST_RINGING;
                    cnt_nx = 2'd0;
                end
            end
            ST_RINGING: begin
                if (!armed || adjust)                       nxt_st = ST_IDLE;
                else if (dismiss_btn)                       nxt_st = ST_IDLE;
                else if (snooze_btn && snooze_count < MAX_SNZ) begin
                    nxt_st = ST_SNOOZING;
                    cnt_nx = snooze_count + 2'd1;
                end
                else if (sec_tick && ring_tc)               nxt_st = ST_IDLE;
            end
            ST_SNOOZING: begin
                if (!armed || adjust)                       nxt_st = ST_IDLE;
                else if (dismiss_btn)                       nxt_st = ST_IDLE;
                else if (sec_tick && snz_tc)                nxt_st = ST_RINGING;
            end
            default: nxt_st = ST_IDLE;
        endcase
        if (nxt_st == ST_IDLE)
            cnt_nx = 2'd0;
    end

    // match_d resets high so a match already present at release cannot trigger.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_st       <= ST_IDLE;
            snooze_count <= 2'd0;
            match_d      <= 1'b1;
            phase        <= 1'b1;
        end else begin
            cur_st       <= nxt_st;
            snooze_count <= cnt_nx;
            match_d      <= match;
            if (!in_ring)
                phase <= 1'b1;
            else if (beep_tc)
                phase <= ~phase;
        end
    end

    assign state      = cur_st;
    assign alarm_on   = in_ring;
    assign snooze_led = in_snz;
    assign buzzer_en  = in_ring & phase;

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Directed bench for alarm_snooze_ctrl with shortened timing (4 s ring, 6 s snooze, 2 snoozes, beep /3).
module tb_alarm_snooze_ctrl;
    logic       clk = 1'b0;
    logic       rst, sec_tick, match, armed, adjust, snooze_btn, dismiss_btn;
    logic       alarm_on, buzzer_en, snooze_led;
    logic [1:0] state, snooze_count;
    int vectors = 0;
    int miscompares = 0;

    alarm_snooze_ctrl #(.RING_SECS(4), .SNOOZE_SECS(6), .MAX_SNOOZE(2), .BEEP_DIV(3)) dut (
        .clk(clk), .rst(rst), .sec_tick(sec_tick), .match(match), .armed(armed),
        .adjust(adjust), .snooze_btn(snooze_btn), .dismiss_btn(dismiss_btn),
        .alarm_on(alarm_on), .buzzer_en(buzzer_en), .snooze_led(snooze_led),
        .state(state), .snooze_count(snooze_count)
    );

    always #5 clk = ~clk;

    task automatic tick_clk();
        @(posedge clk); #1;
    endtask

    task automatic pulse_sec();
        sec_tick = 1'b1; tick_clk(); sec_tick = 1'b0;
    endtask

    task automatic fresh_edge();
        match = 1'b0; tick_clk(); match = 1'b1; tick_clk();
    endtask

    task automatic test_reset();
        rst = 1'b0; sec_tick = 0; match = 1; armed = 1; adjust = 0; snooze_btn = 0; dismiss_btn = 0;
        repeat (2) tick_clk();
        vectors++;
        if ({state, alarm_on, buzzer_en, snooze_led, snooze_count} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got st=%b on=%b bz=%b led=%b cnt=%0d want all 0",
                     state, alarm_on, buzzer_en, snooze_led, snooze_count);
        end
        @(negedge clk); rst = 1'b1;
        repeat (3) tick_clk();
        vectors++;
        if (state !== 2'b00) begin
            miscompares++; $display("FAIL match_at_release got st=%b want 00", state);
        end
    endtask

    task automatic test_ring_beep();
        fresh_edge();
        vectors++;
        if (state !== 2'b01 || alarm_on !== 1'b1) begin
            miscompares++; $display("FAIL ring_start got st=%b on=%b want 01/1", state, alarm_on);
        end
        for (int k = 0; k < 9; k++) begin
            if (k > 0) tick_clk();
            vectors++;
            if (buzzer_en !== (((k / 3) % 2) == 0)) begin
                miscompares++; $display("FAIL beep_pattern k=%0d got %b want %b", k, buzzer_en, ((k / 3) % 2) == 0);
            end
        end
        repeat (3) pulse_sec();
        vectors++;
        if (state !== 2'b01) begin
            miscompares++; $display("FAIL ring_before_timeout got st=%b want 01", state);
        end
        pulse_sec();
        vectors++;
        if (state !== 2'b00 || alarm_on !== 1'b0) begin
            miscompares++; $display("FAIL ring_timeout got st=%b on=%b want 00/0", state, alarm_on);
        end
    endtask

    task automatic test_snooze();
        fresh_edge();
        snooze_btn = 1; tick_clk(); snooze_btn = 0;
        vectors++;
        if (state !== 2'b10 || snooze_led !== 1'b1 || snooze_count !== 2'd1 || alarm_on !== 1'b0) begin
            miscompares++; $display("FAIL snooze1 got st=%b led=%b cnt=%0d on=%b want 10/1/1/0",
                                    state, snooze_led, snooze_count, alarm_on);
        end
        repeat (5) pulse_sec();
        vectors++;
        if (state !== 2'b10) begin
            miscompares++; $display("FAIL snooze_hold got st=%b want 10", state);
        end
        pulse_sec();
        vectors++;
        if (state !== 2'b01 || buzzer_en !== 1'b1 || snooze_count !== 2'd1) begin
            miscompares++; $display("FAIL snooze_expire got st=%b bz=%b cnt=%0d want 01/1/1", state, buzzer_en, snooze_count);
        end
        snooze_btn = 1; tick_clk(); snooze_btn = 0;
        vectors++;
        if (state !== 2'b10 || snooze_count !== 2'd2) begin
            miscompares++; $display("FAIL snooze2 got st=%b cnt=%0d want 10/2", state, snooze_count);
        end
        repeat (6) pulse_sec();
        snooze_btn = 1; tick_clk(); snooze_btn = 0;
        vectors++;
        if (state !== 2'b01 || snooze_count !== 2'd2) begin
            miscompares++; $display("FAIL snooze_limit got st=%b cnt=%0d want 01/2", state, snooze_count);
        end
        repeat (3) pulse_sec();
        vectors++;
        if (state !== 2'b01) begin
            miscompares++; $display("FAIL limit_still_ringing got st=%b want 01", state);
        end
        pulse_sec();
        vectors++;
        if (state !== 2'b00 || snooze_count !== 2'd0) begin
            miscompares++; $display("FAIL limit_timeout got st=%b cnt=%0d want 00/0", state, snooze_count);
        end
    endtask

    task automatic test_dismiss_snooze_together();
        fresh_edge();
        snooze_btn = 1; dismiss_btn = 1; tick_clk(); snooze_btn = 0; dismiss_btn = 0;
        vectors++;
        if (state !== 2'b00 || snooze_count !== 2'd0) begin
            miscompares++; $display("FAIL dismiss_wins got st=%b cnt=%0d want 00/0", state, snooze_count);
        end
        repeat (3) tick_clk();
        vectors++;
        if (state !== 2'b00) begin
            miscompares++; $display("FAIL no_retrigger got st=%b want 00", state);
        end
        fresh_edge();
        vectors++;
        if (state !== 2'b01) begin
            miscompares++; $display("FAIL retrigger got st=%b want 01", state);
        end
        dismiss_btn = 1; tick_clk(); dismiss_btn = 0;
    endtask

    task automatic test_adjust();
        fresh_edge();
        snooze_btn = 1; tick_clk(); snooze_btn = 0;
        adjust = 1; tick_clk();
        vectors++;
        if (state !== 2'b00 || snooze_led !== 1'b0 || snooze_count !== 2'd0) begin
            miscompares++; $display("FAIL adjust_abort got st=%b led=%b cnt=%0d want 00/0/0", state, snooze_led, snooze_count);
        end
        fresh_edge();
        vectors++;
        if (state !== 2'b00) begin
            miscompares++; $display("FAIL adjust_blocks_trig got st=%b want 00", state);
        end
        adjust = 0; tick_clk();
        vectors++;
        if (state !== 2'b00) begin
            miscompares++; $display("FAIL adjust_release got st=%b want 00", state);
        end
    endtask

    task automatic test_async_reset();
        fresh_edge();
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (alarm_on !== 1'b0 || buzzer_en !== 1'b0 || state !== 2'b00) begin
            miscompares++; $display("FAIL async_reset got on=%b bz=%b st=%b want 0/0/00", alarm_on, buzzer_en, state);
        end
        @(negedge clk); rst = 1'b1;
        repeat (2) tick_clk();
        vectors++;
        if (state !== 2'b00) begin
            miscompares++; $display("FAIL post_reset_match got st=%b want 00", state);
        end
    endtask

    task automatic test_back_to_back();
        fresh_edge();
        repeat (3) pulse_sec();
        sec_tick = 1; snooze_btn = 1; tick_clk(); sec_tick = 0; snooze_btn = 0;
        vectors++;
        if (state !== 2'b10 || snooze_count !== 2'd1) begin
            miscompares++; $display("FAIL snooze_vs_timeout got st=%b cnt=%0d want 10/1", state, snooze_count);
        end
        dismiss_btn = 1; tick_clk(); dismiss_btn = 0;
        vectors++;
        if (state !== 2'b00 || snooze_led !== 1'b0) begin
            miscompares++; $display("FAIL snooze_dismiss got st=%b led=%b want 00/0", state, snooze_led);
        end
    endtask

    initial begin
        test_reset();
        test_ring_beep();
        test_snooze();
        test_dismiss_snooze_together();
        test_adjust();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
